// File: rtl/test_bus.sv
// test_bus: memory-access multiplexer between the test controller (master)
// and the CPU core, plus a sticky end-of-test flag raised by a core write to
// the mailbox address.
//
// Optional feature: define TEST_BUS_WATCHDOG_EN to build a cycle watchdog
// that also raises finish after TIMEOUT_CYCLES core-owned clocks.
module test_bus #(
  parameter logic [31:0] FINISH_ADDRESS  = 32'h0000_3FFC,
  parameter int          PAGE_BYTES_LOG2 = 8,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        option,
  input  logic [5:0]  memory_page_number,
  output logic        finish,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  output logic [31:0] core_read_data,
  output logic        memory_read,
  output logic        memory_write,
  output logic [31:0] memory_address,
  output logic [31:0] memory_write_data,
  input  logic [31:0] memory_read_data
);

  // Only the in-page offset of a master address is meaningful.
  logic unused_address_bits;
  assign unused_address_bits = ^address[31:PAGE_BYTES_LOG2];

  logic [31:0] paged_address;
  logic        mailbox_write;
  logic        finish_set;

  // Master byte offset placed inside the selected page, zero-extended.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    paged_address = '0;
    paged_address[PAGE_BYTES_LOG2 +: 6]     = memory_page_number;
    paged_address[PAGE_BYTES_LOG2-1:0]      = address[PAGE_BYTES_LOG2-1:0];
  end

  // The mailbox write only counts while the core owns the memory port.
  assign mailbox_write = !option && core_write && (core_address == FINISH_ADDRESS);

  // Ownership mux: strobes gated by reset, data and address always follow owner.
  always_comb begin
    memory_read       = 1'b0;
    memory_write      = 1'b0;
    memory_address    = core_address;
    memory_write_data = core_write_data;
    read_data         = '0;
    core_read_data    = '0;
    if (option) begin
      memory_read       = read;
      memory_write      = write;
      memory_address    = paged_address;
      memory_write_data = write_data;
      read_data         = memory_read_data;
    end else begin
      memory_read       = core_read;
      memory_write      = core_write && !mailbox_write;
      core_read_data    = memory_read_data;
    end
    if (reset) begin
      memory_read  = 1'b0;
      memory_write = 1'b0;
    end
  end

`ifdef TEST_BUS_WATCHDOG_EN
  logic [31:0] wd_count;
  logic        wd_counting;
  logic        wd_expire;

  assign wd_counting = !option && !finish;
  // The edge that brings the count to TIMEOUT_CYCLES is the one that sets finish.
  assign wd_expire   = wd_counting && (wd_count == TIMEOUT_CYCLES - 32'd1);

  // Watchdog counter: counts core-owned cycles until finish, then holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wd_count <= '0;
    else if (wd_counting)
      wd_count <= wd_count + 32'd1;
  end

  assign finish_set = mailbox_write || wd_expire;
`else
  assign finish_set = mailbox_write;
`endif

  // Sticky end-of-test flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset)
      finish <= 1'b0;
    else if (finish_set)
      finish <= 1'b1;
  end

endmodule

// File: tb/tb_test_bus.sv
// Self-checking bench for test_bus: a behavioural model of the bus rules is
// compared against every output on each falling edge, alongside directed
// literal checks taken from hand-computed values.
module tb_test_bus;

  localparam logic [31:0] FIN  = 32'h0000_3FFC;
  localparam int          PB   = 8;
  localparam int          TOUT = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        option;
  logic [5:0]  memory_page_number;
  logic        finish;
  logic        read, write;
  logic [31:0] address, write_data, read_data;
  logic        core_read, core_write;
  logic [31:0] core_address, core_write_data, core_read_data;
  logic        memory_read, memory_write;
  logic [31:0] memory_address, memory_write_data, memory_read_data;

  int n_cmp  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  always #5 clk = ~clk;

  test_bus #(
    .FINISH_ADDRESS (FIN),
    .PAGE_BYTES_LOG2(PB),
    .TIMEOUT_CYCLES (32'(TOUT))
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .option            (option),
    .memory_page_number(memory_page_number),
    .finish            (finish),
    .read              (read),
    .write             (write),
    .address           (address),
    .write_data        (write_data),
    .read_data         (read_data),
    .core_read         (core_read),
    .core_write        (core_write),
    .core_address      (core_address),
    .core_write_data   (core_write_data),
    .core_read_data    (core_read_data),
    .memory_read       (memory_read),
    .memory_write      (memory_write),
    .memory_address    (memory_address),
    .memory_write_data (memory_write_data),
    .memory_read_data  (memory_read_data)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model of the finish flag: mailbox write by the core owner, or (with the
  // watchdog) TOUT core-owned cycles without finish, whichever comes first.
  logic m_finish;
  int   m_cycles;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_finish <= 1'b0;
      m_cycles <= 0;
    end else if (!m_finish) begin
      if (!option && core_write && core_address == FIN) m_finish <= 1'b1;
`ifdef TEST_BUS_WATCHDOG_EN
      if (!option) begin
        m_cycles <= m_cycles + 1;
        if (m_cycles + 1 == TOUT) m_finish <= 1'b1;
      end
`endif
    end
  end

  // Compare process: every output against the rules, on each falling edge.
  always @(negedge clk) begin
    if (run) begin
      logic [31:0] e_addr, e_wd, e_rd, e_crd;
      logic        e_mr, e_mw;
      if (option) begin
        e_addr = (32'(memory_page_number) << PB) + (address % (32'd1 << PB));
        e_wd   = write_data;
        e_mr   = read;
        e_mw   = write;
        e_rd   = memory_read_data;
        e_crd  = 32'd0;
      end else begin
        e_addr = core_address;
        e_wd   = core_write_data;
        e_mr   = core_read;
        e_mw   = core_write && (core_address != FIN);
        e_rd   = 32'd0;
        e_crd  = memory_read_data;
      end
      if (reset) begin
        e_mr = 1'b0;
        e_mw = 1'b0;
      end
      check("m_memory_read",       32'(memory_read),  32'(e_mr));
      check("m_memory_write",      32'(memory_write), 32'(e_mw));
      check("m_memory_address",    memory_address,    e_addr);
      check("m_memory_write_data", memory_write_data, e_wd);
      check("m_read_data",         read_data,         e_rd);
      check("m_core_read_data",    core_read_data,    e_crd);
      check("m_finish",            32'(finish),       32'(m_finish));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read = 0; write = 0; address = 0; write_data = 0;
    core_read = 0; core_write = 0; core_address = 0; core_write_data = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; option = 0; memory_page_number = 0; memory_read_data = 32'hCAFE_0001;
    idle();
    run = 1;
    #2;
    check("reset_finish", 32'(finish), 32'd0);
    step(); step();
    reset = 0;

    // Core owner write then read.
    core_write = 1; core_address = 32'h10; core_write_data = 32'hDEAD_BEEF;
    #2;
    check("core_wr_strobe", 32'(memory_write), 32'd1);
    check("core_wr_addr",   memory_address,    32'h10);
    check("core_wr_data",   memory_write_data, 32'hDEAD_BEEF);
    step();
    core_write = 0; core_read = 1; memory_read_data = 32'h1234_5678;
    #2;
    check("core_rd_data",   core_read_data, 32'h1234_5678);
    check("core_rd_master", read_data,      32'd0);
    step();

    // Master paging with core strobes (including a mailbox write) ignored.
    idle();
    option = 1; memory_page_number = 6'd3; address = 32'h1234; read = 1;
    core_read = 1; core_write = 1; core_address = FIN; core_write_data = 32'h1;
    memory_read_data = 32'hA5A5_0F0F;
    #2;
    check("pg_addr",      memory_address,   32'h334);
    check("pg_read",      32'(memory_read), 32'd1);
    check("pg_nowrite",   32'(memory_write), 32'd0);
    check("pg_read_data", read_data,        32'hA5A5_0F0F);
    check("pg_core_rd",   core_read_data,   32'd0);
    step();
    check("pg_no_finish", 32'(finish), 32'd0);
    // Master read and write together, top page, offset boundary.
    idle();
    memory_page_number = 6'h3F; address = 32'hFFFF_FFFF; read = 1; write = 1;
    write_data = 32'h0BAD_F00D;
    #2;
    check("pg_max_addr", memory_address,    32'h3FFF);
    check("pg_both_wr",  32'(memory_write), 32'd1);
    check("pg_both_rd",  32'(memory_read),  32'd1);
    check("pg_wdata",    memory_write_data, 32'h0BAD_F00D);
    step();

    // Mailbox: core reads the address normally, write is swallowed.
    idle();
    option = 0; core_read = 1; core_address = FIN;
    #2;
    check("mb_read_pass", 32'(memory_read), 32'd1);
    step();
    core_read = 0; core_write = 1; core_write_data = 32'h1;
    #2;
    check("mb_suppress",  32'(memory_write), 32'd0);
    check("mb_not_yet",   32'(finish),       32'd0);
    step();
    check("mb_finish",    32'(finish), 32'd1);
    idle();
    step(); step();
    check("mb_sticky",    32'(finish), 32'd1);

    // Async reset mid-access.
    core_read = 1; core_write = 1; core_address = 32'h20;
    #2;
    reset = 1;
    #1;
    check("rst_finish",  32'(finish),       32'd0);
    check("rst_mread",   32'(memory_read),  32'd0);
    check("rst_mwrite",  32'(memory_write), 32'd0);
    check("rst_addr",    memory_address,    32'h20);
    step();
    idle();
    option = 0;
    reset = 0;

    // Watchdog window: TOUT core-owned cycles with no mailbox write.
    repeat (TOUT - 1) step();
    check("wd_before", 32'(finish), 32'd0);
    step();
`ifdef TEST_BUS_WATCHDOG_EN
    check("wd_fire",   32'(finish), 32'd1);
`else
    check("wd_absent", 32'(finish), 32'd0);
`endif
    repeat (5) step();

    run = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/test_bus.md
# test_bus

Memory-access multiplexer and end-of-test detector between the test controller (master), the CPU core and the shared memory in the FPGA tester top level. It grants the memory port to either the core or the controller according to `option`. It translates controller accesses into paged memory addresses. It raises a sticky `finish` flag when the core writes the end-of-test mailbox address.

## Interface
Parameters:
- `FINISH_ADDRESS`, default 32'h0000_3FFC: core byte address whose write signals end of test.
- `PAGE_BYTES_LOG2`, default 8: log2 of page size in bytes; 256-byte pages.
- `TIMEOUT_CYCLES`, default 32'd50_000_000: watchdog limit. Only used with `TEST_BUS_WATCHDOG_EN`.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `option`  in  1  owner select: 0 = core, 1 = master
- `memory_page_number`  in  6  page selected for master accesses
- `finish`  out  1  sticky end-of-test flag
- `read`, `write`  in  1 each  master request strobes
- `address`, `write_data`  in  32 each  master byte offset within page; master write data
- `read_data`  out  32  data returned to master
- `core_read`, `core_write`  in  1 each  core request strobes
- `core_address`, `core_write_data`  in  32 each  core byte address; core write data
- `core_read_data`  out  32  data returned to core
- `memory_read`, `memory_write`  out  1 each  memory strobes
- `memory_address`, `memory_write_data`  out  32 each  memory byte address; memory write data
- `memory_read_data`  in  32  memory return data

## Operation
Path selection is combinational from the current `option`; there are no transaction boundaries.

Core path (`option`=0):
- The four memory request outputs mirror the core signals.
- `core_read_data` = `memory_read_data`.
- `read_data` = 0.
- Master strobes are ignored.

Master path (`option`=1):
- `memory_address` = {`memory_page_number`, `address[PAGE_BYTES_LOG2-1:0]`}, zero-extended to 32 bits.
- Upper bits of `address` are ignored.
- `memory_read`/`memory_write`/`memory_write_data` come from the master.
- `read_data` = `memory_read_data`.
- `core_read_data` = 0.
- Core strobes are ignored.

Mailbox / finish:
- A core write with `core_address` == `FINISH_ADDRESS` while `option`=0 is the mailbox write.
- The mailbox write is suppressed toward memory: `memory_write`=0 that cycle, so the memory image stays clean.
- It sets `finish` on the next rising edge.
- `finish` stays 1 until `reset`.
- Core reads of `FINISH_ADDRESS` pass to memory normally.
- Master writes never set `finish`.

Reset:
- While `reset`=1, `memory_read`=`memory_write`=0 regardless of inputs. Data/address outputs still follow the mux.
- `finish` clears asynchronously on `reset`.
- `read_data` and `core_read_data` follow the mux (combinational, no reset value).

## Timing
- All request paths and read-data paths: zero-cycle combinational latency. Memory read latency is whatever the memory imposes; the bus adds none.
- `finish`: registered. It rises 1 cycle after the mailbox write is sampled.
- Simultaneous strobes:
  - `read` and `write` together: both are forwarded; the memory resolves.
  - Master and core strobes together: only the current owner's strobes pass.
- `option` toggling mid-access: ownership switches in the same cycle; the in-flight read data goes to the new owner. Controllers must hold `option` stable across an access.
- `reset` asserted mid-access: strobes drop immediately; `finish` clears immediately.

## Configuration
- `TEST_BUS_WATCHDOG_EN` defined:
  - A 32-bit counter resets to 0 and increments every clock while `option`=0 and `finish`=0.
  - When the count reaches `TIMEOUT_CYCLES`, `finish` sets on that edge, exactly as if the mailbox had been written.
  - The counter then holds.
  - `reset` clears the counter.
- Not defined: no counter is built; `finish` is set only by the mailbox write.

## Test plan
- Core owner: `option`=0, `core_write`=1, `core_address`=0x10, data 0xDEADBEEF -> `memory_write`=1, `memory_address`=0x10, `memory_write_data`=0xDEADBEEF; then `core_read` -> `core_read_data` equals memory data, `read_data`=0.
- Master paging: `option`=1, page=3, `address`=0x1234 -> `memory_address`=0x334; core strobes asserted simultaneously -> ignored.
- Mailbox: `option`=0, core writes 0x1 to 0x3FFC -> `memory_write`=0 that cycle; `finish`=1 next edge and stays 1 after strobes drop.
- Mailbox while master owns (`option`=1, core writes 0x3FFC) -> `finish` stays 0.
- Reset: with `finish`=1 and strobes active, assert `reset` -> `finish`=0 and `memory_read`=`memory_write`=0 without a clock edge.
- Watchdog, `TEST_BUS_WATCHDOG_EN` defined, `TIMEOUT_CYCLES`=100, `option`=0, no mailbox write -> `finish` rises at cycle 100. Macro undefined -> `finish` stays 0.
